// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, default widths
// and the buffered instruction entry.
package fetch_pkg;

  localparam int FETCH_AW = 8;
  localparam int FETCH_IW = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_IW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer between instruction memory and decode.
// Flush takes precedence over push and pop in the same cycle.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives PC hold/load and instruction memory reads,
// tags each read with its address and buffers returns for decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int IW = FETCH_IW
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic [AW-1:0] pc,
  output logic         pc_load,
  output logic [AW-1:0] pc_load_addr,
  output logic         imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output fetch_state_t dbg_state
);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  fetch_state_t  state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          pop, push, flush, full, empty, can_issue;
  logic [1:0]    count;
  logic [2:0]    occ_sum;
  entry_t        push_entry, head_entry;

  // Decode handshake: an entry transfers on any cycle where out_valid and
  // out_ready are both high; the head stays stable until that happens.
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign out_instr  = head_entry.instr;
  assign out_pc     = head_entry.pc;
  assign dbg_state  = state_q;

  // An issue now lands in the buffer next cycle, so reserve its slot today.
  assign occ_sum    = {1'b0, count} + {2'b00, inflight_q};
  assign can_issue  = occ_sum < (3'd2 + {2'b00, pop});
  assign flush      = (state_q != ST_IDLE) && redirect_valid;
  assign push       = inflight_q && !flush;
  assign push_entry = {imem_rdata, inflight_pc_q};

  always_comb begin
    state_d       = state_q;
    imem_en       = 1'b0;
    imem_addr     = pc;
    pc_load       = 1'b1;
    pc_load_addr  = pc;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      default: begin
        if (redirect_valid) begin
          pc_load_addr = redirect_addr;
          state_d      = ST_REDIRECT;
        end else if (!run) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_REDIRECT) begin
          state_d = ST_FETCH;
        end else if (can_issue) begin
          imem_en       = 1'b1;
          pc_load       = 1'b0;
          inflight_d    = 1'b1;
          inflight_pc_d = pc;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_STALL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_fifo #(
    .entry_t(entry_t)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head_entry),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC-stage model and a
// one-cycle-latency instruction memory model.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         run;
  logic [7:0]   pc = 8'h00;
  logic         pc_load;
  logic [7:0]   pc_load_addr;
  logic         imem_en;
  logic [7:0]   imem_addr;
  logic [15:0]  imem_rdata = 16'hDEAD;
  logic         redirect_valid;
  logic [7:0]   redirect_addr;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_instr;
  logic [7:0]   out_pc;
  fetch_state_t dbg_state;
  logic         pc_set_en = 1'b0;
  logic [7:0]   pc_set_val = 8'h00;
  int           total = 0;
  int           bad = 0;

  instruction_fetch #(.AW(8), .IW(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .pc            (pc),
    .pc_load       (pc_load),
    .pc_load_addr  (pc_load_addr),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (pc_set_en)    pc <= pc_set_val;
    else if (pc_load) pc <= pc_load_addr;
    else              pc <= pc + 8'd1;
  end

  always @(posedge clk) imem_rdata <= imem_en ? instr_of(imem_addr) : 16'hDEAD;

  // Leaves the DUT in IDLE with reset released, mid-cycle, pc == a.
  task automatic start_at(input logic [7:0] a);
    @(negedge clk);
    reset_n = 1'b0; run = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 8'h00; pc_set_en = 1'b1; pc_set_val = a;
    @(negedge clk);
    reset_n = 1'b1; pc_set_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_addr = 8'h00; pc_set_en = 1'b1; pc_set_val = 8'h10;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en: got %0b want 0", imem_en); end
    total++; if (pc_load !== 1'b1 || pc_load_addr !== 8'h10) begin bad++; $display("FAIL reset_pc_load: got %0b/%0h want 1/10", pc_load, pc_load_addr); end
    total++; if (out_instr !== 16'h0 || out_pc !== 8'h0) begin bad++; $display("FAIL reset_out: got %0h/%0h want 0/0", out_instr, out_pc); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_stream();
    logic [7:0] a;
    start_at(8'h10); run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      a = 8'h10 + 8'(i);
      total++; if (imem_en !== 1'b1 || imem_addr !== a || pc_load !== 1'b0) begin bad++; $display("FAIL stream_issue[%0d]: got en=%0b addr=%0h ld=%0b want 1/%0h/0", i, imem_en, imem_addr, pc_load, a); end
      total++; if (out_valid !== (i >= 2)) begin bad++; $display("FAIL stream_valid[%0d]: got %0b want %0b", i, out_valid, (i >= 2)); end
      if (i >= 2) begin
        a = 8'h10 + 8'(i - 2);
        total++; if (out_pc !== a || out_instr !== instr_of(a)) begin bad++; $display("FAIL stream_out[%0d]: got %0h/%0h want %0h/%0h", i, out_pc, out_instr, a, instr_of(a)); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit         exp_en [8];
    bit         exp_v  [8];
    logic [7:0] exp_addr [8];
    logic [7:0] exp_pc [8];
    exp_en   = '{1, 1, 0, 0, 0, 1, 1, 1};
    exp_v    = '{0, 0, 1, 1, 1, 1, 1, 1};
    exp_addr = '{8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h22, 8'h23, 8'h24};
    exp_pc   = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h21, 8'h22};
    start_at(8'h20); run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = (i >= 5);
      #1;
      total++; if (imem_en !== exp_en[i]) begin bad++; $display("FAIL bp_en[%0d]: got %0b want %0b", i, imem_en, exp_en[i]); end
      if (exp_en[i]) begin
        total++; if (imem_addr !== exp_addr[i]) begin bad++; $display("FAIL bp_addr[%0d]: got %0h want %0h", i, imem_addr, exp_addr[i]); end
      end else begin
        total++; if (pc_load !== 1'b1 || pc_load_addr !== exp_addr[i]) begin bad++; $display("FAIL bp_hold[%0d]: got %0b/%0h want 1/%0h", i, pc_load, pc_load_addr, exp_addr[i]); end
      end
      total++; if (out_valid !== exp_v[i]) begin bad++; $display("FAIL bp_valid[%0d]: got %0b want %0b", i, out_valid, exp_v[i]); end
      if (exp_v[i]) begin
        total++; if (out_pc !== exp_pc[i] || out_instr !== instr_of(exp_pc[i])) begin bad++; $display("FAIL bp_out[%0d]: got %0h/%0h want %0h/%0h", i, out_pc, out_instr, exp_pc[i], instr_of(exp_pc[i])); end
      end
      if (i == 3) begin
        total++; if (dbg_state !== ST_STALL) begin bad++; $display("FAIL bp_state: got %0d want 2", dbg_state); end
      end
    end
  endtask

  task automatic test_redirect();
    bit         exp_en [6];
    logic [7:0] exp_addr [6];
    exp_en   = '{1, 0, 0, 1, 1, 1};
    exp_addr = '{8'h30, 8'h40, 8'h40, 8'h40, 8'h41, 8'h42};
    start_at(8'h30); run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      redirect_valid = (i == 1); redirect_addr = 8'h40;
      #1;
      total++; if (imem_en !== exp_en[i]) begin bad++; $display("FAIL redir_en[%0d]: got %0b want %0b", i, imem_en, exp_en[i]); end
      if (exp_en[i]) begin
        total++; if (imem_addr !== exp_addr[i]) begin bad++; $display("FAIL redir_addr[%0d]: got %0h want %0h", i, imem_addr, exp_addr[i]); end
      end else begin
        total++; if (pc_load !== 1'b1 || pc_load_addr !== exp_addr[i]) begin bad++; $display("FAIL redir_load[%0d]: got %0b/%0h want 1/%0h", i, pc_load, pc_load_addr, exp_addr[i]); end
      end
      total++; if (out_valid !== (i == 5)) begin bad++; $display("FAIL redir_valid[%0d]: got %0b want %0b", i, out_valid, (i == 5)); end
      if (i == 2) begin
        total++; if (dbg_state !== ST_REDIRECT) begin bad++; $display("FAIL redir_state: got %0d want 3", dbg_state); end
      end
    end
    total++; if (out_pc !== 8'h40 || out_instr !== instr_of(8'h40)) begin bad++; $display("FAIL redir_out: got %0h/%0h want 40/%0h", out_pc, out_instr, instr_of(8'h40)); end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_full();
    start_at(8'h20); run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = (i >= 3); redirect_valid = (i == 3); redirect_addr = 8'h40;
      #1;
      if (i == 3) begin
        total++; if (out_valid !== 1'b1 || imem_en !== 1'b0) begin bad++; $display("FAIL rf_pre: got v=%0b en=%0b want 1/0", out_valid, imem_en); end
        total++; if (pc_load !== 1'b1 || pc_load_addr !== 8'h40) begin bad++; $display("FAIL rf_load: got %0b/%0h want 1/40", pc_load, pc_load_addr); end
      end
      if (i == 4) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_flushed: got %0b want 0", out_valid); end
      end
      if (i == 5) begin
        total++; if (imem_en !== 1'b1 || imem_addr !== 8'h40) begin bad++; $display("FAIL rf_issue: got %0b/%0h want 1/40", imem_en, imem_addr); end
      end
      if (i == 7) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 8'h40) begin bad++; $display("FAIL rf_out: got %0b/%0h want 1/40", out_valid, out_pc); end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    start_at(8'hFE); run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      a = 8'hFE + 8'(i);
      total++; if (imem_en !== 1'b1 || imem_addr !== a || pc_load !== 1'b0) begin bad++; $display("FAIL wrap_issue[%0d]: got %0b/%0h/%0b want 1/%0h/0", i, imem_en, imem_addr, pc_load, a); end
      if (i >= 2) begin
        a = 8'hFE + 8'(i - 2);
        total++; if (out_valid !== 1'b1 || out_pc !== a || out_instr !== instr_of(a)) begin bad++; $display("FAIL wrap_out[%0d]: got %0b/%0h/%0h want 1/%0h/%0h", i, out_valid, out_pc, out_instr, a, instr_of(a)); end
      end
    end
  endtask

  task automatic test_run_drop();
    start_at(8'h60); run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = (i == 0); out_ready = (i >= 4);
      #1;
      if (i == 1) begin
        total++; if (imem_en !== 1'b0 || pc_load !== 1'b1 || pc_load_addr !== 8'h61) begin bad++; $display("FAIL drop_hold: got %0b/%0b/%0h want 0/1/61", imem_en, pc_load, pc_load_addr); end
      end
      if (i == 2) begin
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL drop_state: got %0d want 0", dbg_state); end
      end
      if (i >= 2 && i <= 4) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 8'h60) begin bad++; $display("FAIL drop_retain[%0d]: got %0b/%0h want 1/60", i, out_valid, out_pc); end
      end
      if (i == 5) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_drain: got %0b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    start_at(8'h50); run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b0;
      if (i == 3) begin reset_n = 1'b1; out_ready = 1'b1; end
      #1;
      if (i == 2) begin
        total++; if (out_valid !== 1'b0 || imem_en !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl: got v=%0b en=%0b want 0/0", out_valid, imem_en); end
        total++; if (pc_load !== 1'b1 || pc_load_addr !== 8'h52) begin bad++; $display("FAIL rst_mid_pc: got %0b/%0h want 1/52", pc_load, pc_load_addr); end
        total++; if (out_instr !== 16'h0 || out_pc !== 8'h0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_mid_out: got %0h/%0h/%0d want 0/0/0", out_instr, out_pc, dbg_state); end
      end
      if (i >= 3 && i <= 5) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale[%0d]: got %0b want 0", i, out_valid); end
      end
      if (i == 4) begin
        total++; if (imem_en !== 1'b1 || imem_addr !== 8'h52) begin bad++; $display("FAIL rst_reissue: got %0b/%0h want 1/52", imem_en, imem_addr); end
      end
      if (i == 6) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 8'h52) begin bad++; $display("FAIL rst_first_out: got %0b/%0h want 1/52", out_valid, out_pc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_run_drop();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter AW, default 8, instruction address width (matches PC width).
REQ-002 Parameter IW, default 16, instruction word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  enables fetching; low holds block in IDLE.
REQ-006 pc  input  AW  current program counter value from the PC stage.
REQ-007 pc_load  output  1  drives the PC load input; high = PC takes pc_load_addr next edge.
REQ-008 pc_load_addr  output  AW  address the PC loads when pc_load high.
REQ-009 imem_en  output  1  instruction-memory read enable.
REQ-010 imem_addr  output  AW  instruction-memory read address.
REQ-011 imem_rdata  input  IW  read data; valid exactly 1 cycle after imem_en high.
REQ-012 redirect_valid  input  1  branch/jump taken (from execute).
REQ-013 redirect_addr  input  AW  branch/jump target.
REQ-014 out_valid  output  1  fetched instruction available to decode.
REQ-015 out_ready  input  1  decode accepts instruction this cycle.
REQ-016 out_instr  output  IW  fetched instruction word.
REQ-017 out_pc  output  AW  address of out_instr.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, STALL, REDIRECT.
REQ-019 IDLE: imem_en=0, pc_load=1, pc_load_addr=pc (PC held); run=1 -> FETCH.
REQ-020 FETCH: imem_en=1, imem_addr=pc, pc_load=0 (PC increments); the issued pc SHALL be tagged in-flight for one cycle.
REQ-021 Returning imem_rdata with its tag SHALL be written into a 2-entry FIFO skid buffer the cycle after issue.
REQ-022 out_valid SHALL equal buffer non-empty; out_instr/out_pc SHALL show the head entry; pop on out_valid && out_ready.
REQ-023 Fetch SHALL issue only if (occupancy + in-flight - pop) < 2; otherwise FSM enters STALL with imem_en=0, pc_load=1, pc_load_addr=pc.
REQ-024 STALL -> FETCH the first cycle the REQ-023 condition allows an issue; no instruction SHALL be lost or duplicated.
REQ-025 redirect_valid in any non-IDLE state SHALL: flush buffer, kill in-flight data, assert pc_load=1 with pc_load_addr=redirect_addr, imem_en=0, go to REDIRECT.
REQ-026 REDIRECT lasts exactly one cycle (bubble), then FETCH; first post-redirect issue uses imem_addr=redirect_addr.
REQ-027 Priority: redirect_valid > run deassert > stall > fetch.
REQ-028 run deasserted in FETCH/STALL -> IDLE after completing any in-flight write; buffer contents retained.
REQ-029 Same-cycle pop and push SHALL keep occupancy unchanged; FIFO pointers wrap modulo 2.
REQ-030 out_instr/out_pc SHALL remain stable while out_valid && !out_ready.
REQ-031 Address arithmetic is AW-bit, wrapping 2^AW-1 -> 0 with no special handling.

Reset
REQ-032 reset_n low SHALL immediately force: state=IDLE, buffer empty, in-flight cleared, out_valid=0, imem_en=0, pc_load=1, pc_load_addr=pc, out_instr=0, out_pc=0.
REQ-033 Reset mid-fetch SHALL discard any returning imem_rdata.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the FSM state enum, AW/IW defaults and a fetch_entry_t struct {instr, pc}.
REQ-035 The 2-entry buffer SHALL be a sub-module fetch_skid_fifo (push/pop/full/empty, parameterised on fetch_entry_t).

Verification
REQ-036 Reset release, run=1, pc starts 0x10, out_ready=1 -> out_valid first high 2 cycles after first issue; out_pc 0x10,0x11,0x12 on consecutive cycles.
REQ-037 out_ready=0 for 5 cycles from 0x20 -> buffer fills with 0x20,0x21; pc_load=1 holding pc=0x22; release -> 0x20,0x21,0x22 delivered in order, none lost.
REQ-038 redirect_valid with redirect_addr=0x40 while 0x30 in flight -> 0x30 never presented; next out_pc=0x40 after one bubble cycle.
REQ-039 Simultaneous redirect and full buffer with out_ready=1 -> redirect wins; buffer empty next cycle, pc_load_addr=0x40.
REQ-040 pc=0xFF fetch -> next out_pc=0x00, no stall.
REQ-041 reset_n pulsed low mid-stall -> all outputs at REQ-032 values within the same cycle; no stale instruction after release.
